// File: rtl/sm_addsub_pipe_if.sv
// Handshake bundle for sm_addsub_pipe: operand channel (in_*, a, b, op)
// and result channel (out_*, c, overflow). The slave modport is the
// adder's view; the master modport is the operand source / result sink.
interface sm_addsub_pipe_if #(
  parameter int W = 5
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         op;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] c;
  logic         overflow;

  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, c, overflow
  );

  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, c, overflow
  );
endinterface

// File: rtl/sm_addsub_pipe.sv
// sm_addsub_pipe: 2-stage pipelined sign-magnitude adder/subtractor.
// S1 converts both operands to (W+1)-bit two's complement (B's sign is
// flipped for subtraction, -0 becomes +0). S2 adds and converts back to
// sign-magnitude, flagging overflow when |sum| exceeds 2^(W-1)-1.
// Optional build macro SM_ADDSUB_SAT_EN: saturate C to {sign, all ones}
// on overflow instead of truncating the magnitude.
module sm_addsub_pipe #(
  parameter int W = 5
) (
  input logic             clk,
  input logic             rst,
  sm_addsub_pipe_if.slave bus
);

  localparam logic [W:0] MAX_MAG = (W+1)'((1 << (W-1)) - 1);

  // Sign-magnitude to two's complement; -0 naturally maps to 0.
  function automatic logic [W:0] to_tc(input logic sign, input logic [W-2:0] mag);
    logic [W:0] ext;
    ext = {2'b00, mag};
    return sign ? -ext : ext;
  endfunction

  logic         s1_valid;
  logic [W:0]   s1_a;
  logic [W:0]   s1_b;
  logic         s2_valid;
  logic [W-1:0] c_q;
  logic         ovf_q;

  logic         s2_load;
  logic         in_ready;

  logic [W:0]   sum;
  logic [W:0]   abs_sum;
  logic         neg;
  logic         ovf_n;
  logic [W-2:0] mag_n;
  logic [W-1:0] c_n;

  // Stall control: S2 takes a new value when empty or draining this cycle;
  // S1 takes a new value when empty or moving into S2 this cycle.
  assign s2_load  = !s2_valid || bus.out_ready;
  assign in_ready = !s1_valid || s2_load;

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = s2_valid;
  assign bus.c         = c_q;
  assign bus.overflow  = ovf_q;

  // Add the S1 operands and convert the sum back to sign-magnitude.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned, which would infer a latch.
    sum     = s1_a + s1_b;
    neg     = sum[W];
    abs_sum = neg ? -sum : sum;
    ovf_n   = abs_sum > MAX_MAG;
`ifdef SM_ADDSUB_SAT_EN
    mag_n   = ovf_n ? '1 : abs_sum[W-2:0];
`else
    mag_n   = abs_sum[W-2:0];
`endif
    // A zero magnitude (including one left by truncation) is always +0.
    c_n     = {neg && (mag_n != '0), mag_n};
  end

  // Stage 1: capture operands as two's complement on an input transfer.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement or block order.
    if (rst) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
    end else if (in_ready) begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        s1_a <= to_tc(bus.a[W-1], bus.a[W-2:0]);
        s1_b <= to_tc(bus.b[W-1] ^ bus.op, bus.b[W-2:0]);
      end
    end
  end

  // Stage 2: register the result; C and overflow hold while stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      c_q      <= '0;
      ovf_q    <= 1'b0;
    end else if (s2_load) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        c_q   <= c_n;
        ovf_q <= ovf_n;
      end
    end
  end

endmodule

// File: tb/tb_sm_addsub_pipe.sv
// Directed bench for sm_addsub_pipe (W=5): arithmetic vectors, -0 handling,
// overflow with truncation or saturation (SM_ADDSUB_SAT_EN), backpressure
// ordering/stability, and mid-flight reset.
module tb_sm_addsub_pipe;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  sm_addsub_pipe_if #(.W(5)) bus ();

  sm_addsub_pipe #(.W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

`ifdef SM_ADDSUB_SAT_EN
  localparam logic [4:0] E_POS16 = 5'b01111;
  localparam logic [4:0] E_NEG16 = 5'b11111;
  localparam logic [4:0] E_NEG30 = 5'b11111;
  localparam logic [4:0] E_POS30 = 5'b01111;
`else
  localparam logic [4:0] E_POS16 = 5'b00000;
  localparam logic [4:0] E_NEG16 = 5'b00000;
  localparam logic [4:0] E_NEG30 = 5'b11110;
  localparam logic [4:0] E_POS30 = 5'b01110;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One op with no backpressure: accepted now, result visible 2 cycles later.
  task automatic run_op(input string tag, input logic [4:0] a, input logic [4:0] b,
                        input logic op, input logic [4:0] exp_c, input logic exp_ovf);
    bus.a = a; bus.b = b; bus.op = op; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    #1;
    check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check({tag, "_early"}, 32'(bus.out_valid), 32'd0);
    @(posedge clk); #1;
    check({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    check({tag, "_c"}, 32'(bus.c), 32'(exp_c));
    check({tag, "_ovf"}, 32'(bus.overflow), 32'(exp_ovf));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  logic [4:0] bp_a [6];
  logic [4:0] bp_b [6];
  logic       bp_op[6];
  logic [4:0] bp_c [6];
  int         idx_in, idx_out, cyc;
  logic       prev_stalled, saw_in_ready_low;
  logic [4:0] prev_c;
  logic       prev_ovf;

  initial begin
    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.op = 1'b0; bus.out_ready = 1'b1;

    // Reset state
    @(posedge clk); @(posedge clk); #1;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_c", 32'(bus.c), 32'd0);
    check("rst_ovf", 32'(bus.overflow), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

    // Arithmetic vectors
    run_op("add_3_m5",   5'b00011, 5'b10101, 1'b0, 5'b10010, 1'b0);
    run_op("sub_7_m3",   5'b00111, 5'b10011, 1'b1, 5'b01010, 1'b0);
    run_op("sub_4_4",    5'b00100, 5'b00100, 1'b1, 5'b00000, 1'b0);
    run_op("neg0_neg0",  5'b10000, 5'b10000, 1'b0, 5'b00000, 1'b0);
    run_op("sub_m3_2",   5'b10011, 5'b00010, 1'b1, 5'b10101, 1'b0);
    run_op("max_no_ovf", 5'b01111, 5'b10000, 1'b0, 5'b01111, 1'b0);
    run_op("ovf_p16",    5'b01111, 5'b00001, 1'b0, E_POS16, 1'b1);
    run_op("ovf_m16",    5'b11111, 5'b10001, 1'b0, E_NEG16, 1'b1);
    run_op("ovf_m30",    5'b11111, 5'b11111, 1'b0, E_NEG30, 1'b1);
    run_op("ovf_p30",    5'b01111, 5'b11111, 1'b1, E_POS30, 1'b1);
    @(posedge clk); #1;

    // Backpressure: 6 back-to-back ops, out_ready low for cycles 3..6
    bp_a  = '{5'b00001, 5'b00101, 5'b10110, 5'b00011, 5'b00010, 5'b11000};
    bp_b  = '{5'b00010, 5'b00001, 5'b00001, 5'b00011, 5'b01001, 5'b00000};
    bp_op = '{1'b0,     1'b1,     1'b0,     1'b0,     1'b1,     1'b0};
    bp_c  = '{5'b00011, 5'b00100, 5'b10101, 5'b00110, 5'b10111, 5'b11000};
    idx_in = 0; idx_out = 0; cyc = 0;
    prev_stalled = 1'b0; saw_in_ready_low = 1'b0; prev_c = '0; prev_ovf = 1'b0;
    while (idx_out < 6 && cyc < 40) begin
      bus.out_ready = !(cyc >= 3 && cyc < 7);
      bus.in_valid  = (idx_in < 6);
      if (idx_in < 6) begin
        bus.a = bp_a[idx_in]; bus.b = bp_b[idx_in]; bus.op = bp_op[idx_in];
      end
      #1;
      if (bus.out_valid && bus.out_ready) begin
        check($sformatf("bp_c%0d", idx_out), 32'(bus.c), 32'(bp_c[idx_out]));
        check($sformatf("bp_ovf%0d", idx_out), 32'(bus.overflow), 32'd0);
        idx_out++;
      end
      if (bus.out_valid && !bus.out_ready) begin
        if (prev_stalled) begin
          check($sformatf("bp_stable_c_cyc%0d", cyc), 32'(bus.c), 32'(prev_c));
          check($sformatf("bp_stable_ovf_cyc%0d", cyc), 32'(bus.overflow), 32'(prev_ovf));
        end
        prev_stalled = 1'b1; prev_c = bus.c; prev_ovf = bus.overflow;
      end else begin
        prev_stalled = 1'b0;
      end
      if (!bus.out_ready && !bus.in_ready) saw_in_ready_low = 1'b1;
      if (bus.in_valid && bus.in_ready) idx_in++;
      @(posedge clk); #1;
      cyc++;
    end
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    check("bp_all_out", 32'(idx_out), 32'd6);
    check("bp_in_ready_dropped", 32'(saw_in_ready_low), 32'd1);
    @(posedge clk); #1;
    check("bp_drained", 32'(bus.out_valid), 32'd0);

    // Mid-flight reset with two ops held under backpressure
    bus.out_ready = 1'b0;
    bus.a = 5'b00011; bus.b = 5'b00011; bus.op = 1'b0; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.a = 5'b00001; bus.b = 5'b00001;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check("rst2_pre_valid", 32'(bus.out_valid), 32'd1);
    check("rst2_pre_c", 32'(bus.c), 32'h06);
    check("rst2_pre_in_ready", 32'(bus.in_ready), 32'd0);
    rst = 1'b1;
    #1;
    check("rst2_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst2_c", 32'(bus.c), 32'd0);
    check("rst2_ovf", 32'(bus.overflow), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; bus.out_ready = 1'b1;
    #1;
    check("rst2_in_ready", 32'(bus.in_ready), 32'd1);
    run_op("after_rst", 5'b00101, 5'b10001, 1'b0, 5'b00100, 1'b0);
    @(posedge clk); #1;
    check("after_rst_no_replay", 32'(bus.out_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
